hs32_fetch_resp: RTL and testbench

Instruction-memory responder for the fetch port of the memory arbiter interface. It accepts single-word read strobes (`stbm` + `addr`) from the fetch unit, reads a synchronous single-port SRAM with a configurable number of wait states, and returns the word on `dtr` with a one-cycle `ackm`. It answers with a one-cycle `stlm` whenever it cannot take a request.

---
 rtl/hs32_fetch_resp.sv | 133 +++++++++++++
 tb/tb_hs32_fetch_resp.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_fetch_resp.sv
// Fetch-port instruction-memory responder: accepts single-word read strobes,
// reads a synchronous SRAM with optional wait states, and answers with ackm or stlm.
module hs32_fetch_resp #(
    parameter int          AW          = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] FAULT_WORD  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   addr,
    input  logic          stbm,
    output logic [31:0]   dtr,
    output logic          ackm,
    output logic          stlm,
    input  logic          hold,
    output logic          fault,
    output logic          sram_ce,
    output logic [AW-1:0] sram_addr,
    input  logic [31:0]   sram_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          fault_flag, fault_flag_nx;
    logic          stall_pend, stall_pend_nx;
    logic [31:0]   dtr_nx;
    logic          ackm_nx, stlm_nx, fault_nx, sram_ce_nx;
    logic [AW-1:0] sram_addr_nx;
    logic          in_range;
    logic          unused_addr_bits;

    assign in_range         = (addr >> (AW + 2)) == 32'd0;
    assign unused_addr_bits = ^addr[1:0];

    // NOTE: every variable gets a default before the case so no latch can be inferred.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        fault_flag_nx = fault_flag;
        stall_pend_nx = 1'b0;
        dtr_nx        = dtr;
        ackm_nx       = 1'b0;
        stlm_nx       = 1'b0;
        fault_nx      = 1'b0;
        sram_ce_nx    = 1'b0;
        sram_addr_nx  = sram_addr;

        case (state)
            S_IDLE: begin
                stlm_nx = stall_pend;
                if (stbm) begin
                    if (hold) begin
                        stlm_nx = 1'b1;
                    end else begin
                        state_nx = S_READ;
                        if (in_range) begin
                            sram_ce_nx    = 1'b1;
                            sram_addr_nx  = addr[AW+1:2];
                            fault_flag_nx = 1'b0;
                        end else begin
                            fault_flag_nx = 1'b1;
                        end
                    end
                end
            end
            S_READ: begin
                stlm_nx = stbm;
                if (WS == 4'd0) begin
                    state_nx = S_RESP;
                end else begin
                    cnt_nx   = WS;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                stlm_nx = stbm;
                cnt_nx  = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                // A strobe seen here is stalled one cycle late so ackm and stlm never overlap.
                stall_pend_nx = stbm;
                dtr_nx        = fault_flag ? FAULT_WORD : sram_dout;
                ackm_nx       = 1'b1;
                fault_nx      = fault_flag;
                fault_flag_nx = 1'b0;
                state_nx      = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            fault_flag <= 1'b0;
            stall_pend <= 1'b0;
            dtr        <= 32'd0;
            ackm       <= 1'b0;
            stlm       <= 1'b0;
            fault      <= 1'b0;
            sram_ce    <= 1'b0;
            sram_addr  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            fault_flag <= fault_flag_nx;
            stall_pend <= stall_pend_nx;
            dtr        <= dtr_nx;
            ackm       <= ackm_nx;
            stlm       <= stlm_nx;
            fault      <= fault_nx;
            sram_ce    <= sram_ce_nx;
            sram_addr  <= sram_addr_nx;
        end
    end

endmodule

// File: tb/tb_hs32_fetch_resp.sv
// Bench for hs32_fetch_resp: two instances (0 and 3 wait states) share the stimulus;
// directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_hs32_fetch_resp;

    localparam logic [31:0] FW = 32'hBAD0_F00D;

    logic        clk, reset, stbm, hold;
    logic [31:0] addr;
    logic [31:0] dtr_o   [2];
    logic        ackm_o  [2];
    logic        stlm_o  [2];
    logic        fault_o [2];
    logic        ce_o    [2];
    logic [11:0] sa_o    [2];
    logic [31:0] dout0, dout1;
    logic [31:0] mem [4096];

    int n_cmp  = 0;
    int n_bad  = 0;
    int edge_n = 0;

    // Reference model: one outstanding transaction per instance, described by the
    // edge at which its ack is due plus the word it will return.
    int          resp_edge  [2];
    bit          pend_fault [2];
    logic [31:0] pend_word  [2];
    logic        exp_ack    [2];
    logic        exp_stl    [2];
    logic        exp_ce     [2];
    logic        exp_fault  [2];
    logic [31:0] exp_dtr    [2];
    logic [11:0] exp_sa     [2];
    bit          stl_map [int];

    hs32_fetch_resp #(.AW(12), .WAIT_STATES(0), .FAULT_WORD(FW)) u_ws0 (
        .clk(clk), .reset(reset), .addr(addr), .stbm(stbm), .dtr(dtr_o[0]),
        .ackm(ackm_o[0]), .stlm(stlm_o[0]), .hold(hold), .fault(fault_o[0]),
        .sram_ce(ce_o[0]), .sram_addr(sa_o[0]), .sram_dout(dout0)
    );

    hs32_fetch_resp #(.AW(12), .WAIT_STATES(3), .FAULT_WORD(FW)) u_ws3 (
        .clk(clk), .reset(reset), .addr(addr), .stbm(stbm), .dtr(dtr_o[1]),
        .ackm(ackm_o[1]), .stlm(stlm_o[1]), .hold(hold), .fault(fault_o[1]),
        .sram_ce(ce_o[1]), .sram_addr(sa_o[1]), .sram_dout(dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ce_o[0]) dout0 <= mem[sa_o[0]];
    always @(posedge clk) if (ce_o[1]) dout1 <= mem[sa_o[1]];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        stl_map.delete();
        for (int i = 0; i < 2; i++) begin
            resp_edge[i]  = -1000;
            pend_fault[i] = 1'b0;
            pend_word[i]  = 32'd0;
            exp_ack[i]    = 1'b0;
            exp_stl[i]    = 1'b0;
            exp_ce[i]     = 1'b0;
            exp_fault[i]  = 1'b0;
            exp_dtr[i]    = 32'd0;
            exp_sa[i]     = 12'd0;
        end
    endtask

    task automatic model_edge(input logic s, input logic h, input logic [31:0] a);
        int ws;
        for (int i = 0; i < 2; i++) begin
            ws        = (i == 0) ? 0 : 3;
            exp_ce[i] = 1'b0;
            if (edge_n > resp_edge[i]) begin
                if (s && !h) begin
                    resp_edge[i]  = edge_n + 2 + ws;
                    pend_fault[i] = (a[31:14] != 18'd0);
                    pend_word[i]  = pend_fault[i] ? FW : mem[a[13:2]];
                    if (!pend_fault[i]) begin
                        exp_ce[i] = 1'b1;
                        exp_sa[i] = a[13:2];
                    end
                end else if (s) begin
                    stl_map[2 * edge_n + i] = 1'b1;
                end
            end else if (s) begin
                if (edge_n == resp_edge[i]) stl_map[2 * (edge_n + 1) + i] = 1'b1;
                else                        stl_map[2 * edge_n + i] = 1'b1;
            end
            exp_ack[i]   = (edge_n == resp_edge[i]);
            exp_fault[i] = exp_ack[i] && pend_fault[i];
            if (exp_ack[i]) exp_dtr[i] = pend_word[i];
            exp_stl[i]   = stl_map.exists(2 * edge_n + i);
        end
    endtask

    // Drive one cycle of inputs, advance one rising edge, and leave time #1 after it.
    task automatic step(input logic s, input logic h, input logic [31:0] a);
        stbm = s;
        hold = h;
        addr = a;
        @(posedge clk);
        edge_n++;
        model_edge(s, h, a);
        #1;
    endtask

    task automatic drain();
        repeat (8) step(1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stbm  = 1'b0;
        hold  = 1'b0;
        addr  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ackm_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset ackm[%0d]: got %b want 0", i, ackm_o[i]); end
            n_cmp++; if (stlm_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset stlm[%0d]: got %b want 0", i, stlm_o[i]); end
            n_cmp++; if (fault_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset fault[%0d]: got %b want 0", i, fault_o[i]); end
            n_cmp++; if (ce_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset sram_ce[%0d]: got %b want 0", i, ce_o[i]); end
            n_cmp++; if (sa_o[i] !== 12'd0) begin n_bad++; $display("FAIL reset sram_addr[%0d]: got %h want 0", i, sa_o[i]); end
            n_cmp++; if (dtr_o[i] !== 32'd0) begin n_bad++; $display("FAIL reset dtr[%0d]: got %h want 0", i, dtr_o[i]); end
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_read();
        int ack_at [2];
        int n_ack  [2];
        int n_ce1;
        mem[5] = 32'hDEAD_BEEF;
        ack_at = '{-1, -1};
        n_ack  = '{0, 0};
        n_ce1  = 0;
        step(1'b1, 1'b0, 32'h14);
        n_cmp++; if (ce_o[0] !== 1'b1) begin n_bad++; $display("FAIL single sram_ce[0]: got %b want 1", ce_o[0]); end
        n_cmp++; if (sa_o[0] !== 12'd5) begin n_bad++; $display("FAIL single sram_addr[0]: got %h want 5", sa_o[0]); end
        n_cmp++; if (ce_o[1] !== 1'b1) begin n_bad++; $display("FAIL single sram_ce[1]: got %b want 1", ce_o[1]); end
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 32'd0);
            if (ce_o[1]) n_ce1++;
            for (int i = 0; i < 2; i++) begin
                if (ackm_o[i]) begin
                    ack_at[i] = k;
                    n_ack[i]++;
                    n_cmp++; if (dtr_o[i] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single dtr[%0d]: got %h want deadbeef", i, dtr_o[i]); end
                    n_cmp++; if (fault_o[i] !== 1'b0) begin n_bad++; $display("FAIL single fault[%0d]: got %b want 0", i, fault_o[i]); end
                end
            end
            if (k == 4) begin
                n_cmp++; if (dtr_o[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single dtr_hold: got %h want deadbeef", dtr_o[0]); end
            end
        end
        n_cmp++; if (ack_at[0] != 2) begin n_bad++; $display("FAIL single ack_edge[0]: got %0d want 2", ack_at[0]); end
        n_cmp++; if (ack_at[1] != 5) begin n_bad++; $display("FAIL wait ack_edge[1]: got %0d want 5", ack_at[1]); end
        n_cmp++; if (n_ack[0] != 1 || n_ack[1] != 1) begin n_bad++; $display("FAIL single ack_count: got %0d/%0d want 1/1", n_ack[0], n_ack[1]); end
        n_cmp++; if (n_ce1 != 0) begin n_bad++; $display("FAIL wait extra_ce_pulses: got %0d want 0", n_ce1); end
    endtask

    task automatic test_stalls();
        mem[8] = 32'h1234_5678;
        step(1'b1, 1'b0, 32'h20);
        step(1'b1, 1'b0, 32'h30);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (stlm_o[i] !== 1'b1) begin n_bad++; $display("FAIL busy stlm[%0d]: got %b want 1", i, stlm_o[i]); end
            n_cmp++; if (ce_o[i] !== 1'b0) begin n_bad++; $display("FAIL busy sram_ce[%0d]: got %b want 0", i, ce_o[i]); end
        end
        step(1'b0, 1'b0, 32'd0);
        n_cmp++; if (stlm_o[0] !== 1'b0) begin n_bad++; $display("FAIL busy stlm_len: got %b want 0", stlm_o[0]); end
        n_cmp++; if (ackm_o[0] !== 1'b1) begin n_bad++; $display("FAIL busy ackm[0]: got %b want 1", ackm_o[0]); end
        n_cmp++; if (dtr_o[0] !== 32'h1234_5678) begin n_bad++; $display("FAIL busy dtr[0]: got %h want 12345678", dtr_o[0]); end
        drain();
        step(1'b1, 1'b1, 32'h24);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (stlm_o[i] !== 1'b1) begin n_bad++; $display("FAIL hold stlm[%0d]: got %b want 1", i, stlm_o[i]); end
            n_cmp++; if (ce_o[i] !== 1'b0) begin n_bad++; $display("FAIL hold sram_ce[%0d]: got %b want 0", i, ce_o[i]); end
        end
        step(1'b0, 1'b0, 32'd0);
        n_cmp++; if (stlm_o[0] !== 1'b0) begin n_bad++; $display("FAIL hold stlm_len: got %b want 0", stlm_o[0]); end
        drain();
    endtask

    task automatic test_out_of_range();
        int ack_at [2];
        ack_at = '{-1, -1};
        step(1'b1, 1'b0, 32'h0000_4000);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ce_o[i] !== 1'b0) begin n_bad++; $display("FAIL oor sram_ce[%0d]: got %b want 0", i, ce_o[i]); end
            n_cmp++; if (sa_o[i] !== 12'd8) begin n_bad++; $display("FAIL oor sram_addr[%0d]: got %h want 8", i, sa_o[i]); end
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 32'd0);
            for (int i = 0; i < 2; i++) begin
                if (ackm_o[i]) begin
                    ack_at[i] = k;
                    n_cmp++; if (fault_o[i] !== 1'b1) begin n_bad++; $display("FAIL oor fault[%0d]: got %b want 1", i, fault_o[i]); end
                    n_cmp++; if (dtr_o[i] !== FW) begin n_bad++; $display("FAIL oor dtr[%0d]: got %h want %h", i, dtr_o[i], FW); end
                end else begin
                    n_cmp++; if (fault_o[i] !== 1'b0) begin n_bad++; $display("FAIL oor fault_len[%0d]: got %b want 0", i, fault_o[i]); end
                end
            end
        end
        n_cmp++; if (ack_at[0] != 2 || ack_at[1] != 5) begin n_bad++; $display("FAIL oor ack_edges: got %0d/%0d want 2/5", ack_at[0], ack_at[1]); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 32'h40);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        n_cmp++; if (ackm_o[0] !== 1'b1) begin n_bad++; $display("FAIL b2b ackm[0]: got %b want 1", ackm_o[0]); end
        step(1'b1, 1'b0, 32'h44);
        n_cmp++; if (ce_o[0] !== 1'b1) begin n_bad++; $display("FAIL b2b sram_ce[0]: got %b want 1", ce_o[0]); end
        n_cmp++; if (sa_o[0] !== 12'd17) begin n_bad++; $display("FAIL b2b sram_addr[0]: got %h want 11", sa_o[0]); end
        n_cmp++; if (stlm_o[0] !== 1'b0) begin n_bad++; $display("FAIL b2b stlm[0]: got %b want 0", stlm_o[0]); end
        n_cmp++; if (stlm_o[1] !== 1'b1) begin n_bad++; $display("FAIL b2b stlm[1]: got %b want 1", stlm_o[1]); end
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'h48);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ackm_o[i] !== 1'b1) begin n_bad++; $display("FAIL resp_strobe ackm[%0d]: got %b want 1", i, ackm_o[i]); end
            n_cmp++; if (stlm_o[i] !== 1'b0) begin n_bad++; $display("FAIL resp_strobe stlm_overlap[%0d]: got %b want 0", i, stlm_o[i]); end
        end
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (stlm_o[i] !== 1'b1) begin n_bad++; $display("FAIL resp_strobe stlm_late[%0d]: got %b want 1", i, stlm_o[i]); end
            n_cmp++; if (ce_o[i] !== 1'b0) begin n_bad++; $display("FAIL resp_strobe sram_ce[%0d]: got %b want 0", i, ce_o[i]); end
        end
        drain();
    endtask

    task automatic test_streaming();
        int pc, cyc;
        int got [$];
        int exp_seq [7];
        bit busy, drop, flushed;
        exp_seq = '{0, 1, 2, 8, 9, 10, 11};
        pc = 0; cyc = 0; busy = 1'b0; drop = 1'b0; flushed = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = 32'(k);
        while (got.size() < 7 && cyc < 400) begin
            cyc++;
            if (!busy) begin
                step(1'b1, 1'b0, 32'(pc * 4));
                if (!stlm_o[0]) begin
                    busy = 1'b1;
                    if (pc == 3 && !flushed) begin
                        flushed = 1'b1;
                        drop    = 1'b1;
                        pc      = 8;
                        step(1'b1, 1'b0, 32'(pc * 4));
                        n_cmp++; if (stlm_o[0] !== 1'b1) begin n_bad++; $display("FAIL stream flush_stlm: got %b want 1", stlm_o[0]); end
                    end
                end
            end else begin
                step(1'b0, 1'b0, 32'd0);
                if (ackm_o[0]) begin
                    busy = 1'b0;
                    if (drop) drop = 1'b0;
                    else begin
                        got.push_back(int'(dtr_o[0]));
                        pc++;
                    end
                end
            end
        end
        n_cmp++; if (got.size() != 7) begin n_bad++; $display("FAIL stream count: got %0d want 7 (cycles %0d)", got.size(), cyc); end
        for (int j = 0; j < 7; j++) begin
            if (j < got.size()) begin
                n_cmp++; if (got[j] != exp_seq[j]) begin n_bad++; $display("FAIL stream word[%0d]: got %0d want %0d", j, got[j], exp_seq[j]); end
            end
        end
        drain();
    endtask

    task automatic test_random();
        logic        s, h;
        logic [31:0] a;
        for (int k = 0; k < 2000; k++) begin
            s = ($urandom_range(99) < 40);
            h = ($urandom_range(99) < 20);
            if ($urandom_range(9) == 0) a = $urandom | 32'h0001_0000;
            else                        a = {18'd0, 12'($urandom), 2'($urandom)};
            step(s, h, a);
            for (int i = 0; i < 2; i++) begin
                n_cmp++; if (ackm_o[i] !== exp_ack[i]) begin n_bad++; $display("FAIL rnd ackm[%0d] edge %0d: got %b want %b", i, edge_n, ackm_o[i], exp_ack[i]); end
                n_cmp++; if (stlm_o[i] !== exp_stl[i]) begin n_bad++; $display("FAIL rnd stlm[%0d] edge %0d: got %b want %b", i, edge_n, stlm_o[i], exp_stl[i]); end
                n_cmp++; if (fault_o[i] !== exp_fault[i]) begin n_bad++; $display("FAIL rnd fault[%0d] edge %0d: got %b want %b", i, edge_n, fault_o[i], exp_fault[i]); end
                n_cmp++; if (ce_o[i] !== exp_ce[i]) begin n_bad++; $display("FAIL rnd sram_ce[%0d] edge %0d: got %b want %b", i, edge_n, ce_o[i], exp_ce[i]); end
                n_cmp++; if (sa_o[i] !== exp_sa[i]) begin n_bad++; $display("FAIL rnd sram_addr[%0d] edge %0d: got %h want %h", i, edge_n, sa_o[i], exp_sa[i]); end
                n_cmp++; if (dtr_o[i] !== exp_dtr[i]) begin n_bad++; $display("FAIL rnd dtr[%0d] edge %0d: got %h want %h", i, edge_n, dtr_o[i], exp_dtr[i]); end
                n_cmp++; if ((ackm_o[i] & stlm_o[i]) !== 1'b0) begin n_bad++; $display("FAIL rnd ack_stl_overlap[%0d] edge %0d: got 1 want 0", i, edge_n); end
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        int ack_seen;
        int ack_at;
        mem[5] = 32'hCAFE_0005;
        step(1'b1, 1'b0, 32'h14);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ce_o[i] !== 1'b0) begin n_bad++; $display("FAIL areset sram_ce[%0d]: got %b want 0", i, ce_o[i]); end
        end
        model_reset();
        step(1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        step(1'b1, 1'b0, 32'h14);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'h14);
        n_cmp++; if (ackm_o[0] !== 1'b1) begin n_bad++; $display("FAIL areset pre_ackm[0]: got %b want 1", ackm_o[0]); end
        n_cmp++; if (stlm_o[1] !== 1'b1) begin n_bad++; $display("FAIL areset pre_stlm[1]: got %b want 1", stlm_o[1]); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (ackm_o[0] !== 1'b0) begin n_bad++; $display("FAIL areset ackm[0]: got %b want 0", ackm_o[0]); end
        n_cmp++; if (stlm_o[1] !== 1'b0) begin n_bad++; $display("FAIL areset stlm[1]: got %b want 0", stlm_o[1]); end
        n_cmp++; if (dtr_o[0] !== 32'd0) begin n_bad++; $display("FAIL areset dtr[0]: got %h want 0", dtr_o[0]); end
        model_reset();
        step(1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        ack_seen = 0;
        repeat (8) begin
            step(1'b0, 1'b0, 32'd0);
            if (ackm_o[0] || ackm_o[1] || stlm_o[0] || stlm_o[1]) ack_seen++;
        end
        n_cmp++; if (ack_seen != 0) begin n_bad++; $display("FAIL areset stale_ack: got %0d want 0", ack_seen); end

        ack_at = -1;
        step(1'b1, 1'b0, 32'h14);
        n_cmp++; if (ce_o[1] !== 1'b1) begin n_bad++; $display("FAIL areset restart_ce: got %b want 1", ce_o[1]); end
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 32'd0);
            if (ackm_o[1]) begin
                ack_at = k;
                n_cmp++; if (dtr_o[1] !== 32'hCAFE_0005) begin n_bad++; $display("FAIL areset restart_dtr: got %h want cafe0005", dtr_o[1]); end
            end
        end
        n_cmp++; if (ack_at != 5) begin n_bad++; $display("FAIL areset restart_ack_edge: got %0d want 5", ack_at); end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = $urandom;
        model_reset();
        test_reset();
        test_single_read();
        test_stalls();
        test_out_of_range();
        test_back_to_back();
        test_streaming();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
